// File: rtl/digit_serial_adder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : digit_serial_adder_pkg
// Brief    : FSM encoding, default sizing and slice-count helpers shared by
//            the digit-serial adder.
// Revision : 1.0
// ============================================================================
package digit_serial_adder_pkg;

    localparam int DEFAULT_WIDTH = 8;
    localparam int DEFAULT_DIGIT = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int num_slices(input int width, input int digit);
        return width / digit;
    endfunction

    // A single-slice build still needs a one-bit counter.
    function automatic int cnt_width(input int width, input int digit);
        int n;
        n = num_slices(width, digit);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/digit_serial_adder_slice.sv
`default_nettype none
// ============================================================================
// Module   : adder_slice
// Brief    : Combinational DIGIT-bit adder with carry in and carry out.
// Revision : 1.0
// ============================================================================
module adder_slice #(
    parameter int DIGIT = 2
) (
    input  logic [DIGIT-1:0] i_a,
    input  logic [DIGIT-1:0] i_b,
    input  logic             i_cin,
    output logic [DIGIT-1:0] o_sum,
    output logic             o_cout
);

    assign {o_cout, o_sum} = {1'b0, i_a} + {1'b0, i_b} + {{DIGIT{1'b0}}, i_cin};

endmodule
`default_nettype wire

// File: rtl/digit_serial_adder.sv
`default_nettype none
// ============================================================================
// Module   : digit_serial_adder
// Brief    : Adds WIDTH-bit operands DIGIT bits per cycle, LSB first, behind
//            valid/ready handshakes. DIGIT_SERIAL_ADDER_OVF_EN adds io_out_ovf.
// Revision : 1.0
// ============================================================================
module digit_serial_adder
    import digit_serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DIGIT = DEFAULT_DIGIT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             io_in_valid,
    output logic             io_in_ready,
    input  logic [WIDTH-1:0] io_in_lhs,
    input  logic [WIDTH-1:0] io_in_rhs,
    input  logic             io_in_cin,
    output logic             io_out_valid,
    input  logic             io_out_ready,
    output logic [WIDTH-1:0] io_out_sum,
`ifdef DIGIT_SERIAL_ADDER_OVF_EN
    output logic             io_out_ovf,
`endif
    output logic             io_out_cout
);

    localparam int N_SLICES = num_slices(WIDTH, DIGIT);
    localparam int CNT_W    = cnt_width(WIDTH, DIGIT);
    localparam logic [CNT_W-1:0] c_LAST = CNT_W'(N_SLICES - 1);

    generate
        if ((WIDTH % DIGIT) != 0 || WIDTH < DIGIT) begin : g_bad_params
            $error("digit_serial_adder: WIDTH must be a positive multiple of DIGIT");
        end
    endgenerate

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_carry;
    logic [WIDTH-1:0] r_lhs;
    logic [WIDTH-1:0] r_rhs;
    logic [WIDTH-1:0] r_sum;
    logic [DIGIT-1:0] w_slice_sum;
    logic             w_slice_cout;

    // Operands shift right each cycle, so the active slice is always the low digit.
    adder_slice #(.DIGIT(DIGIT)) u_slice (
        .i_a    (r_lhs[DIGIT-1:0]),
        .i_b    (r_rhs[DIGIT-1:0]),
        .i_cin  (r_carry),
        .o_sum  (w_slice_sum),
        .o_cout (w_slice_cout)
    );

`ifdef DIGIT_SERIAL_ADDER_OVF_EN
    logic r_ovf;
    logic w_cmsb;

    // Carry into the word MSB recovered from that bit's sum and operands.
    assign w_cmsb     = r_lhs[DIGIT-1] ^ r_rhs[DIGIT-1] ^ w_slice_sum[DIGIT-1];
    assign io_out_ovf = r_ovf;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ovf <= 1'b0;
        end else if (r_state == IDLE && io_in_valid) begin
            r_ovf <= 1'b0;
        end else if (r_state == BUSY && r_cnt == c_LAST) begin
            r_ovf <= w_cmsb ^ w_slice_cout;
        end
    end
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_carry <= 1'b0;
            r_lhs   <= '0;
            r_rhs   <= '0;
            r_sum   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (io_in_valid) begin
                        r_lhs   <= io_in_lhs;
                        r_rhs   <= io_in_rhs;
                        r_carry <= io_in_cin;
                        r_cnt   <= '0;
                        r_sum   <= '0;
                        r_state <= BUSY;
                    end
                end
                BUSY: begin
                    for (int k = 0; k < N_SLICES; k++) begin
                        if (r_cnt == CNT_W'(k)) begin
                            r_sum[k*DIGIT +: DIGIT] <= w_slice_sum;
                        end
                    end
                    r_lhs   <= r_lhs >> DIGIT;
                    r_rhs   <= r_rhs >> DIGIT;
                    r_carry <= w_slice_cout;
                    if (r_cnt == c_LAST) begin
                        r_state <= DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (io_out_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign io_in_ready  = (r_state == IDLE);
    assign io_out_valid = (r_state == DONE);
    assign io_out_sum   = r_sum;
    assign io_out_cout  = r_carry;

endmodule
`default_nettype wire

// File: tb/tb_digit_serial_adder.sv
`default_nettype none
// ============================================================================
// Module   : tb_digit_serial_adder
// Brief    : Directed self-checking bench for digit_serial_adder (WIDTH=8, DIGIT=2).
// Revision : 1.0
// ============================================================================
module tb_digit_serial_adder;

    logic       clk;
    logic       reset;
    logic       io_in_valid;
    logic       io_in_ready;
    logic [7:0] io_in_lhs;
    logic [7:0] io_in_rhs;
    logic       io_in_cin;
    logic       io_out_valid;
    logic       io_out_ready;
    logic [7:0] io_out_sum;
    logic       io_out_cout;
`ifdef DIGIT_SERIAL_ADDER_OVF_EN
    logic       io_out_ovf;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    digit_serial_adder #(.WIDTH(8), .DIGIT(2)) dut (
        .clk          (clk),
        .reset        (reset),
        .io_in_valid  (io_in_valid),
        .io_in_ready  (io_in_ready),
        .io_in_lhs    (io_in_lhs),
        .io_in_rhs    (io_in_rhs),
        .io_in_cin    (io_in_cin),
        .io_out_valid (io_out_valid),
        .io_out_ready (io_out_ready),
        .io_out_sum   (io_out_sum),
`ifdef DIGIT_SERIAL_ADDER_OVF_EN
        .io_out_ovf   (io_out_ovf),
`endif
        .io_out_cout  (io_out_cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Stimulus only: presents one operand set and waits for the result.
    task automatic do_op(input logic [7:0] lhs, input logic [7:0] rhs, input logic cin,
                         output logic [7:0] sum, output logic cout, output logic ovf,
                         output int lat);
        int n;
        n = 0;
        while (!io_in_ready && n < 20) begin
            step();
            n++;
        end
        io_in_lhs   = lhs;
        io_in_rhs   = rhs;
        io_in_cin   = cin;
        io_in_valid = 1'b1;
        step();
        io_in_valid = 1'b0;
        lat = 0;
        while (!io_out_valid && lat < 20) begin
            step();
            lat++;
        end
        sum  = io_out_sum;
        cout = io_out_cout;
`ifdef DIGIT_SERIAL_ADDER_OVF_EN
        ovf = io_out_ovf;
`else
        ovf = 1'b0;
`endif
    endtask

    task automatic test_reset();
        n_tests++;
        if (io_in_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_in_ready: got %b want 1", io_in_ready);
        end
        n_tests++;
        if (io_out_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_out_valid: got %b want 0", io_out_valid);
        end
        n_tests++;
        if (io_out_sum !== 8'h00) begin
            n_fail++; $display("FAIL reset_sum: got %h want 00", io_out_sum);
        end
        n_tests++;
        if (io_out_cout !== 1'b0) begin
            n_fail++; $display("FAIL reset_cout: got %b want 0", io_out_cout);
        end
    endtask

    task automatic test_basic();
        logic [7:0] s; logic c; logic o; int lat;
        do_op(8'h5A, 8'h3C, 1'b0, s, c, o, lat);
        n_tests++;
        if (lat !== 4) begin
            n_fail++; $display("FAIL basic_latency: got %0d want 4", lat);
        end
        n_tests++;
        if (s !== 8'h96) begin
            n_fail++; $display("FAIL basic_sum: got %h want 96", s);
        end
        n_tests++;
        if (c !== 1'b0) begin
            n_fail++; $display("FAIL basic_cout: got %b want 0", c);
        end
        n_tests++;
        if (io_in_ready !== 1'b0) begin
            n_fail++; $display("FAIL basic_ready_in_done: got %b want 0", io_in_ready);
        end
        step();
        n_tests++;
        if (io_in_ready !== 1'b1 || io_out_valid !== 1'b0) begin
            n_fail++; $display("FAIL basic_return_idle: got ready=%b valid=%b want 1/0",
                               io_in_ready, io_out_valid);
        end
    endtask

    task automatic test_carry();
        logic [7:0] s; logic c; logic o; int lat;
        do_op(8'hFF, 8'h01, 1'b0, s, c, o, lat);
        n_tests++;
        if ({c, s} !== 9'h100) begin
            n_fail++; $display("FAIL carry_ff_01: got %b_%h want 1_00", c, s);
        end
        do_op(8'hFF, 8'hFF, 1'b1, s, c, o, lat);
        n_tests++;
        if ({c, s} !== 9'h1FF) begin
            n_fail++; $display("FAIL carry_ff_ff_1: got %b_%h want 1_ff", c, s);
        end
        do_op(8'h00, 8'h00, 1'b1, s, c, o, lat);
        n_tests++;
        if ({c, s} !== 9'h001) begin
            n_fail++; $display("FAIL carry_cin_only: got %b_%h want 0_01", c, s);
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] s; logic c; logic o; int lat;
        io_out_ready = 1'b0;
        do_op(8'h12, 8'h34, 1'b0, s, c, o, lat);
        n_tests++;
        if (s !== 8'h46 || c !== 1'b0) begin
            n_fail++; $display("FAIL bp_result: got %b_%h want 0_46", c, s);
        end
        io_in_lhs   = 8'hAA;
        io_in_rhs   = 8'h55;
        io_in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            n_tests++;
            if (io_out_valid !== 1'b1 || io_out_sum !== 8'h46 || io_out_cout !== 1'b0
                || io_in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_hold[%0d]: got valid=%b sum=%h cout=%b ready=%b want 1/46/0/0",
                         i, io_out_valid, io_out_sum, io_out_cout, io_in_ready);
            end
        end
        io_in_valid  = 1'b0;
        io_out_ready = 1'b1;
        step();
        n_tests++;
        if (io_in_ready !== 1'b1 || io_out_valid !== 1'b0) begin
            n_fail++; $display("FAIL bp_release: got ready=%b valid=%b want 1/0",
                               io_in_ready, io_out_valid);
        end
        step();
        n_tests++;
        if (io_in_ready !== 1'b1) begin
            n_fail++; $display("FAIL bp_ignored_op: got ready=%b want 1", io_in_ready);
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] s; logic c; logic o; int lat;
        io_in_lhs   = 8'h77;
        io_in_rhs   = 8'h11;
        io_in_cin   = 1'b1;
        io_in_valid = 1'b1;
        step();
        io_in_valid = 1'b0;
        step();
        reset = 1'b0;
        step();
        n_tests++;
        if (io_in_ready !== 1'b1 || io_out_valid !== 1'b0 || io_out_sum !== 8'h00) begin
            n_fail++; $display("FAIL midreset_state: got ready=%b valid=%b sum=%h want 1/0/00",
                               io_in_ready, io_out_valid, io_out_sum);
        end
        reset = 1'b1;
        step();
        do_op(8'h01, 8'h02, 1'b0, s, c, o, lat);
        n_tests++;
        if ({c, s} !== 9'h003 || lat !== 4) begin
            n_fail++; $display("FAIL midreset_followup: got %b_%h lat=%0d want 0_03 lat=4", c, s, lat);
        end
        step();
    endtask

    task automatic test_back_to_back();
        logic [8:0] exp_q[$];
        logic [8:0] exp_v;
        int last_acc;
        int n_acc;
        int n_res;
        last_acc = -100;
        n_acc    = 0;
        n_res    = 0;
        io_in_valid = 1'b1;
        for (int cyc = 0; cyc < 40; cyc++) begin
            io_in_lhs = 8'(cyc * 37 + 11);
            io_in_rhs = 8'(cyc * 53 + 200);
            io_in_cin = cyc[0];
            if (io_out_valid) begin
                exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : 9'h000;
                n_res++;
                n_tests++;
                if ({io_out_cout, io_out_sum} !== exp_v) begin
                    n_fail++; $display("FAIL b2b_result[%0d]: got %b_%h want %b_%h",
                                       n_res, io_out_cout, io_out_sum, exp_v[8], exp_v[7:0]);
                end
            end
            if (io_in_ready) begin
                exp_q.push_back({1'b0, io_in_lhs} + {1'b0, io_in_rhs} + {8'h00, io_in_cin});
                if (n_acc > 0) begin
                    n_tests++;
                    if (cyc - last_acc !== 6) begin
                        n_fail++; $display("FAIL b2b_spacing: got %0d want 6", cyc - last_acc);
                    end
                end
                last_acc = cyc;
                n_acc++;
            end
            step();
        end
        io_in_valid = 1'b0;
        n_tests++;
        if (n_acc < 6 || n_res < 5) begin
            n_fail++; $display("FAIL b2b_count: got acc=%0d res=%0d want >=6/>=5", n_acc, n_res);
        end
        for (int i = 0; i < 8; i++) step();
    endtask

`ifdef DIGIT_SERIAL_ADDER_OVF_EN
    task automatic test_ovf();
        logic [7:0] s; logic c; logic o; int lat;
        do_op(8'h7F, 8'h01, 1'b0, s, c, o, lat);
        n_tests++;
        if (o !== 1'b1 || s !== 8'h80 || c !== 1'b0) begin
            n_fail++; $display("FAIL ovf_7f_01: got ovf=%b sum=%h cout=%b want 1/80/0", o, s, c);
        end
        do_op(8'h80, 8'h80, 1'b0, s, c, o, lat);
        n_tests++;
        if (o !== 1'b1 || s !== 8'h00 || c !== 1'b1) begin
            n_fail++; $display("FAIL ovf_80_80: got ovf=%b sum=%h cout=%b want 1/00/1", o, s, c);
        end
        do_op(8'h10, 8'h20, 1'b0, s, c, o, lat);
        n_tests++;
        if (o !== 1'b0 || s !== 8'h30) begin
            n_fail++; $display("FAIL ovf_10_20: got ovf=%b sum=%h want 0/30", o, s);
        end
        step();
    endtask
`endif

    initial begin
        reset        = 1'b0;
        io_in_valid  = 1'b0;
        io_in_lhs    = 8'h00;
        io_in_rhs    = 8'h00;
        io_in_cin    = 1'b0;
        io_out_ready = 1'b1;
        step();
        step();
        test_reset();
        reset = 1'b1;
        step();
        test_basic();
        test_carry();
        step();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
`ifdef DIGIT_SERIAL_ADDER_OVF_EN
        test_ovf();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
